// File: rtl/sd_card_cmd_if.sv
// Application-side handshake between the SD card CMD responder and the card-emulation logic.
// slave = the CMD responder, master = the emulation logic that answers commands.
interface sd_card_cmd_if;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_argument;
  logic        cmd_crc_error;
  logic        rsp_start;
  logic [5:0]  rsp_index;
  logic [31:0] rsp_data;
  logic        rsp_no_crc;
  logic        rsp_ready;
  logic        rsp_timeout;

  modport master (
    output rsp_start, rsp_index, rsp_data, rsp_no_crc,
    input  cmd_valid, cmd_index, cmd_argument, cmd_crc_error, rsp_ready, rsp_timeout
  );
  modport slave (
    input  rsp_start, rsp_index, rsp_data, rsp_no_crc,
    output cmd_valid, cmd_index, cmd_argument, cmd_crc_error, rsp_ready, rsp_timeout
  );
endinterface

// File: rtl/sd_card_cmd.sv
// Card-side SD CMD line responder: deframes 48-bit host commands and serialises 48-bit short responses.
// Optional macro SD_CARD_CMD_CRC_CHECK_EN builds the received-command CRC7 checker.
module sd_card_cmd #(
  parameter int P_NCR        = 2,
  parameter int P_RSP_WINDOW = 64
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_sd_clk,
  input  logic         i_sd_cmd,
  output logic         o_sd_cmd,
  output logic         o_sd_cmd_oe,
  output logic         o_busy,
  sd_card_cmd_if.slave app
);
  localparam int CW = $clog2(P_RSP_WINDOW + 1);

  typedef enum logic [2:0] {S_IDLE, S_RX, S_WAIT, S_NCR, S_TX} state_e;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    return {c[5:0], 1'b0} ^ ((c[6] ^ b) ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
    return c;
  endfunction

  state_e        state_q;
  logic [2:0]    sclk_q;
  logic [1:0]    cmd_q;
  logic          start_q, rx_done_q;
  logic [5:0]    bcnt_q, tx_cnt_q;
  logic [45:0]   rx_sr_q;
  logic [47:0]   tx_sr_q;
  logic [CW-1:0] ncnt_q;
  logic          sd_cmd_q, oe_q, valid_q, err_q, to_q;
  logic [5:0]    idx_q;
  logic [31:0]   arg_q;

  logic        rise, fall, bit_s, crc_bad;
  logic [47:0] frame_d;
  logic [39:0] rsp_body;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sclk_q <= '0;
      cmd_q  <= '1;
    end else begin
      sclk_q <= {sclk_q[1:0], i_sd_clk};
      cmd_q  <= {cmd_q[0], i_sd_cmd};
    end
  end

  assign rise  =  sclk_q[1] & ~sclk_q[2];
  assign fall  = ~sclk_q[1] &  sclk_q[2];
  assign bit_s =  cmd_q[1];

`ifdef SD_CARD_CMD_CRC_CHECK_EN
  logic [6:0] crc_q;
  // Seeded with the CRC of the start/transmission pair "01" (7'h09), then runs over index+argument.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) crc_q <= '0;
    else if (state_q == S_IDLE && rise && start_q && bit_s) crc_q <= 7'h09;
    else if (state_q == S_RX && !rx_done_q && rise && bcnt_q > 6'd8) crc_q <= crc7_step(crc_q, bit_s);
  end
  assign crc_bad = (crc_q != rx_sr_q[7:1]);
`else
  logic unused_crc;
  assign unused_crc = ^rx_sr_q[7:1];
  assign crc_bad    = 1'b0;
`endif

  assign rsp_body = {2'b00, app.rsp_index, app.rsp_data};
  assign frame_d  = {rsp_body, (app.rsp_no_crc ? 7'h7F : crc7_40(rsp_body)), 1'b1};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      rx_done_q <= 1'b0;
      bcnt_q    <= '0;
      tx_cnt_q  <= '0;
      rx_sr_q   <= '0;
      tx_sr_q   <= '0;
      ncnt_q    <= '0;
      sd_cmd_q  <= 1'b1;
      oe_q      <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      to_q      <= 1'b0;
      idx_q     <= '0;
      arg_q     <= '0;
    end else begin
      valid_q <= 1'b0;
      to_q    <= 1'b0;
      case (state_q)
        S_IDLE: if (rise) begin
          if (!start_q) start_q <= ~bit_s;
          else begin
            // "00" is a glitch: drop it and look for a fresh start bit.
            start_q <= 1'b0;
            if (bit_s) begin
              state_q   <= S_RX;
              bcnt_q    <= 6'd46;
              rx_done_q <= 1'b0;
            end
          end
        end
        S_RX: begin
          if (rx_done_q) begin
            valid_q <= 1'b1;
            idx_q   <= rx_sr_q[45:40];
            arg_q   <= rx_sr_q[39:8];
            err_q   <= crc_bad | ~rx_sr_q[0];
            ncnt_q  <= '0;
            state_q <= crc_bad ? S_IDLE : S_WAIT;
          end else if (rise) begin
            rx_sr_q <= {rx_sr_q[44:0], bit_s};
            bcnt_q  <= bcnt_q - 6'd1;
            if (bcnt_q == 6'd1) rx_done_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (rise) ncnt_q <= ncnt_q + 1'b1;
          if (app.rsp_start) begin
            tx_sr_q  <= frame_d;
            tx_cnt_q <= '0;
            state_q  <= (ncnt_q >= CW'(P_NCR)) ? S_TX : S_NCR;
          end else if (ncnt_q == CW'(P_RSP_WINDOW)) begin
            to_q    <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_NCR: begin
          if (rise) ncnt_q <= ncnt_q + 1'b1;
          if (ncnt_q >= CW'(P_NCR)) state_q <= S_TX;
        end
        S_TX: if (fall) begin
          // 48 bits out, then one more fall edge so the end bit is held a full SD clock.
          if (tx_cnt_q != 6'd48) begin
            oe_q     <= 1'b1;
            sd_cmd_q <= tx_sr_q[47];
            tx_sr_q  <= {tx_sr_q[46:0], 1'b0};
            tx_cnt_q <= tx_cnt_q + 6'd1;
          end else begin
            oe_q     <= 1'b0;
            sd_cmd_q <= 1'b1;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_sd_cmd          = sd_cmd_q;
  assign o_sd_cmd_oe       = oe_q;
  assign o_busy            = (state_q != S_IDLE);
  assign app.cmd_valid     = valid_q;
  assign app.cmd_index     = idx_q;
  assign app.cmd_argument  = arg_q;
  assign app.cmd_crc_error = err_q;
  assign app.rsp_ready     = (state_q == S_WAIT);
  assign app.rsp_timeout   = to_q;
endmodule
